// File: rtl/gps_pkg.sv
// Shared constants and helpers for the GPS L1 C/A stimulus generator.
// Also intended for reuse by the receiver tracking channels.
package gps_pkg;

   localparam int CHIPS_PER_EPOCH = 1023;
   localparam int EPOCHS_PER_BIT  = 20;

   localparam logic [9:0] CHIP_LAST  = 10'(CHIPS_PER_EPOCH - 1);
   localparam logic [4:0] EPOCH_LAST = 5'(EPOCHS_PER_BIT - 1);

   localparam logic [2:0] ADDR_NOP         = 3'd0;
   localparam logic [2:0] ADDR_CARRIER_STEP = 3'd1;
   localparam logic [2:0] ADDR_CODE_STEP    = 3'd2;
   localparam logic [2:0] ADDR_G2_INIT      = 3'd3;
   localparam logic [2:0] ADDR_CARRIER_LOAD = 3'd4;
   localparam logic [2:0] ADDR_CODE_LOAD    = 3'd5;
   localparam logic [2:0] ADDR_CLR_UNDERRUN = 3'd6;

   localparam logic [31:0] CARRIER_STEP_RST = 32'h01FF_0000;
   localparam logic [31:0] CODE_STEP_RST    = 32'h0FFF_0000;

   // Bit k holds LFSR stage k+1; stage 10 (bit 9) is the output stage.
   localparam logic [9:0] G1_TAPS      = 10'b10_0000_0100;
   localparam logic [9:0] G2_TAPS      = 10'b11_1010_0110;
   localparam logic [9:0] G1_INIT      = 10'b11_1111_1111;
   localparam logic [9:0] G2_INIT_PRN1 = 10'b00_1101_1111;

   function automatic logic [9:0] lfsr_shift(
      input logic [9:0] state,
      input logic [9:0] taps
   );
      return {state[8:0], ^(state & taps)};
   endfunction

endpackage

// File: rtl/gps_prn_lfsr.sv
// G1/G2 Gold-code generator for GPS C/A codes.
// Shifts on i_shift; i_reload restarts the code period from i_g2_init.
module gps_prn_lfsr
   import gps_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_shift,
   input  logic       i_reload,
   input  logic [9:0] i_g2_init,
   output logic       o_chip
);

   logic [9:0] r_g1;
   logic [9:0] r_g2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_g1 <= G1_INIT;
         r_g2 <= G2_INIT_PRN1;
      end else if (i_reload) begin
         r_g1 <= G1_INIT;
         r_g2 <= i_g2_init;
      end else if (i_shift) begin
         r_g1 <= lfsr_shift(r_g1, G1_TAPS);
         r_g2 <= lfsr_shift(r_g2, G2_TAPS);
      end
   end

   assign o_chip = r_g1[9] ^ r_g2[9];

endmodule

// File: rtl/gps_signal_gen.sv
// Baseband GPS L1 C/A transmitter: 1-bit IF sample =
// carrier sign ^ C/A chip ^ nav data bit.
module gps_signal_gen
   import gps_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_enable,
   input  logic [2:0]  i_address,
   input  logic [31:0] i_data_value,
   input  logic        i_nav_bit,
   input  logic        i_nav_valid,
   output logic        o_nav_ready,
   output logic        o_sample_out,
   output logic        o_code_chip,
   output logic [3:0]  o_carrier_phase_upper,
   output logic        o_epoch,
   output logic        o_bit_edge,
   output logic        o_underrun
);

   logic [31:0] r_carrier_step;
   logic [31:0] r_code_step;
   logic [9:0]  r_g2_init;
   logic [31:0] r_carrier_acc;
   logic [31:0] r_code_acc;
   logic [9:0]  r_chip_cnt;
   logic [4:0]  r_epoch_cnt;
   logic        r_nav_buf;
   logic        r_nav_full;
   logic        r_cur_bit;
   logic        r_underrun;
   logic        r_sample;

   logic        w_wr_carrier_step;
   logic        w_wr_code_step;
   logic        w_wr_g2_init;
   logic        w_carrier_load;
   logic        w_code_load;
   logic        w_clr_underrun;
   logic [32:0] w_code_sum;
   logic        w_chip_tick;
   logic        w_epoch;
   logic        w_bit_edge;
   logic        w_nav_xfer;
   logic        w_underrun_set;
   logic        w_chip;

   assign w_wr_carrier_step = (i_address == ADDR_CARRIER_STEP);
   assign w_wr_code_step    = (i_address == ADDR_CODE_STEP);
   assign w_wr_g2_init      = (i_address == ADDR_G2_INIT);
   assign w_carrier_load    = (i_address == ADDR_CARRIER_LOAD);
   assign w_code_load       = (i_address == ADDR_CODE_LOAD);
   assign w_clr_underrun    = (i_address == ADDR_CLR_UNDERRUN);

   // Chip tick is the carry out of the code NCO; a phase load suppresses it.
   assign w_code_sum  = {1'b0, r_code_acc} + {1'b0, r_code_step};
   assign w_chip_tick = i_enable & ~reset & ~w_code_load & w_code_sum[32];
   assign w_epoch     = w_chip_tick & (r_chip_cnt == CHIP_LAST);
   assign w_bit_edge  = w_epoch & (r_epoch_cnt == EPOCH_LAST);

   assign w_nav_xfer     = i_nav_valid & ~r_nav_full;
   assign w_underrun_set = w_bit_edge & ~r_nav_full & ~w_nav_xfer;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_carrier_step <= CARRIER_STEP_RST;
         r_code_step    <= CODE_STEP_RST;
         r_g2_init      <= G2_INIT_PRN1;
      end else begin
         if (w_wr_carrier_step) r_carrier_step <= i_data_value;
         if (w_wr_code_step)    r_code_step    <= i_data_value;
         if (w_wr_g2_init)      r_g2_init      <= i_data_value[9:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_carrier_acc <= '0;
         r_code_acc    <= '0;
      end else begin
         if (w_carrier_load)
            r_carrier_acc <= i_data_value;
         else if (i_enable)
            r_carrier_acc <= r_carrier_acc + r_carrier_step;
         if (w_code_load)
            r_code_acc <= i_data_value;
         else if (i_enable)
            r_code_acc <= w_code_sum[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_chip_cnt  <= '0;
         r_epoch_cnt <= '0;
      end else if (w_chip_tick) begin
         if (w_epoch) begin
            r_chip_cnt  <= '0;
            r_epoch_cnt <= (r_epoch_cnt == EPOCH_LAST) ? '0
                                                       : r_epoch_cnt + 5'd1;
         end else begin
            r_chip_cnt <= r_chip_cnt + 10'd1;
         end
      end
   end

   gps_prn_lfsr u_prn (
      .clk       (clk),
      .reset     (reset),
      .i_shift   (w_chip_tick),
      .i_reload  (w_epoch),
      .i_g2_init (r_g2_init),
      .o_chip    (w_chip)
   );

   // An arriving bit at an empty-buffer boundary bypasses the buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_nav_buf  <= 1'b0;
         r_nav_full <= 1'b0;
         r_cur_bit  <= 1'b0;
      end else if (w_bit_edge) begin
         r_nav_full <= 1'b0;
         if (r_nav_full)
            r_cur_bit <= r_nav_buf;
         else if (w_nav_xfer)
            r_cur_bit <= i_nav_bit;
         else
            r_cur_bit <= 1'b0;
      end else if (w_nav_xfer) begin
         r_nav_buf  <= i_nav_bit;
         r_nav_full <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_underrun <= 1'b0;
      else if (w_underrun_set)
         r_underrun <= 1'b1;
      else if (w_clr_underrun)
         r_underrun <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_sample <= 1'b0;
      else
         r_sample <= r_carrier_acc[31] ^ w_chip ^ r_cur_bit;
   end

   assign o_nav_ready           = ~r_nav_full;
   assign o_sample_out          = r_sample;
   assign o_code_chip           = w_chip;
   assign o_carrier_phase_upper = r_carrier_acc[31:28];
   assign o_epoch               = w_epoch;
   assign o_bit_edge            = w_bit_edge;
   assign o_underrun            = r_underrun;

endmodule

// File: tb/tb_gps_signal_gen.sv
// Bench for gps_signal_gen: directed scenarios plus a random phase,
// all cycles compared against a chip-index level reference model.
module tb_gps_signal_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [2:0]  addr;
   logic [31:0] data;
   logic        nbit;
   logic        nv;
   logic        nav_ready;
   logic        sample_out;
   logic        code_chip;
   logic [3:0]  phase_upper;
   logic        epoch;
   logic        bit_edge;
   logic        underrun;

   int checks = 0;
   int failures = 0;

   gps_signal_gen dut (
      .clk                   (clk),
      .reset                 (rst),
      .i_enable              (en),
      .i_address             (addr),
      .i_data_value          (data),
      .i_nav_bit             (nbit),
      .i_nav_valid           (nv),
      .o_nav_ready           (nav_ready),
      .o_sample_out          (sample_out),
      .o_code_chip           (code_chip),
      .o_carrier_phase_upper (phase_upper),
      .o_epoch               (epoch),
      .o_bit_edge            (bit_edge),
      .o_underrun            (underrun)
   );

   always #5 clk = ~clk;

   localparam logic [9:0] PRN1_INIT = 10'b0011011111;

   // Reference model state: code position as chip index into a table.
   bit          m_code [0:1022];
   logic [31:0] m_car_acc = 0;
   logic [31:0] m_code_acc = 0;
   logic [31:0] m_car_step = 32'h01FF0000;
   logic [31:0] m_code_step = 32'h0FFF0000;
   logic [9:0]  m_g2_init = PRN1_INIT;
   int          m_chip = 0;
   int          m_ep = 0;
   bit          m_full = 0;
   bit          m_buf = 0;
   bit          m_cur = 0;
   bit          m_und = 0;
   bit          m_sample = 0;

   task automatic regen(input logic [9:0] init);
      bit a [1:10];
      bit b [1:10];
      bit fa;
      bit fb;
      for (int i = 1; i <= 10; i++) begin
         a[i] = 1'b1;
         b[i] = init[i-1];
      end
      for (int n = 0; n < 1023; n++) begin
         m_code[n] = a[10] ^ b[10];
         fa = a[3] ^ a[10];
         fb = b[2] ^ b[3] ^ b[6] ^ b[8] ^ b[9] ^ b[10];
         for (int k = 10; k >= 2; k--) begin
            a[k] = a[k-1];
            b[k] = b[k-1];
         end
         a[1] = fa;
         b[1] = fb;
      end
   endtask

   function automatic bit exp_tick();
      logic [63:0] s;
      s = 64'(m_code_acc) + 64'(m_code_step);
      return en && !rst && (addr != 3'd5) && (s > 64'hFFFF_FFFF);
   endfunction

   function automatic bit exp_epoch();
      return exp_tick() && (m_chip == 1022);
   endfunction

   function automatic bit exp_bit_edge();
      return exp_epoch() && (m_ep == 19);
   endfunction

   task automatic model_edge();
      bit tk;
      bit ep;
      bit be;
      bit xfer;
      if (rst) begin
         m_car_acc = 0; m_code_acc = 0;
         m_car_step = 32'h01FF0000; m_code_step = 32'h0FFF0000;
         m_g2_init = PRN1_INIT;
         m_chip = 0; m_ep = 0;
         m_full = 0; m_buf = 0; m_cur = 0; m_und = 0; m_sample = 0;
         regen(PRN1_INIT);
      end else begin
         tk = exp_tick();
         ep = exp_epoch();
         be = exp_bit_edge();
         xfer = nv && !m_full;
         m_sample = m_car_acc[31] ^ m_code[m_chip] ^ m_cur;
         if (be && !m_full && !xfer) m_und = 1;
         else if (addr == 3'd6) m_und = 0;
         if (be) begin
            if (m_full) m_cur = m_buf;
            else if (xfer) m_cur = nbit;
            else m_cur = 0;
            m_full = 0;
         end else if (xfer) begin
            m_buf = nbit;
            m_full = 1;
         end
         if (addr == 3'd4) m_car_acc = data;
         else if (en) m_car_acc = m_car_acc + m_car_step;
         if (addr == 3'd5) m_code_acc = data;
         else if (en) m_code_acc = m_code_acc + m_code_step;
         if (tk) begin
            if (ep) begin
               m_chip = 0;
               m_ep = (m_ep == 19) ? 0 : m_ep + 1;
               regen(m_g2_init);
            end else begin
               m_chip++;
            end
         end
         if (addr == 3'd1) m_car_step = data;
         if (addr == 3'd2) m_code_step = data;
         if (addr == 3'd3) m_g2_init = data[9:0];
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("model_chip", 32'(code_chip), 32'(m_code[m_chip]));
      chk("model_phase", 32'(phase_upper), 32'(m_car_acc[31:28]));
      chk("model_ready", 32'(nav_ready), 32'(!m_full));
      chk("model_underrun", 32'(underrun), 32'(m_und));
      chk("model_sample", 32'(sample_out), 32'(m_sample));
      chk("model_epoch", 32'(epoch), 32'(exp_epoch()));
      chk("model_bit_edge", 32'(bit_edge), 32'(exp_bit_edge()));
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #2;
         check_all();
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      addr = a;
      data = d;
      run(1);
      addr = 3'd0;
   endtask

   task automatic wait_bit_edge(output int n);
      n = 0;
      while (!bit_edge && n < 25000) begin
         run(1);
         n++;
      end
      chk("bit_edge_seen", 32'(bit_edge), 32'd1);
   endtask

   bit          rec1 [0:1022];
   bit          rec2 [0:1022];
   logic [9:0]  prn1_exp = 10'b1100100000;
   logic [9:0]  v3;
   logic [9:0]  m3;
   logic [9:0]  rnd_g2;
   logic [3:0]  cap_phase;
   int          n;
   int          ep_at;
   int          mism;
   int          chg;
   int          eps;
   bit          p31;
   bit          pc;
   bit          rb;
   bit          cap_chip;

   initial begin
      rst = 1; en = 0; addr = 0; data = 0; nbit = 0; nv = 0;
      regen(PRN1_INIT);
      run(2);
      chk("rst_ready", 32'(nav_ready), 32'd1);
      chk("rst_chip", 32'(code_chip), 32'd1);
      chk("rst_sample", 32'(sample_out), 32'd0);
      chk("rst_phase", 32'(phase_upper), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_epoch", 32'(epoch), 32'd0);
      rst = 0;

      // PRN1 code, period and deferred g2_init
      wr(3'd1, 32'h0);
      wr(3'd2, 32'h80000000);
      en = 1;
      n = 0; ep_at = -1;
      while (n < 2100) begin
         if (n % 2 == 0 && n / 2 < 1023) rec1[n/2] = code_chip;
         if (epoch) begin
            ep_at = n;
            break;
         end
         run(1);
         n++;
      end
      for (int i = 0; i < 10; i++)
         chk("prn1_chip", 32'(rec1[i]), 32'(prn1_exp[9-i]));
      chk("epoch_cycle", 32'(ep_at), 32'd2045);
      run(1);
      rnd_g2 = 10'($urandom_range(1, 1023));
      if (rnd_g2 == PRN1_INIT) rnd_g2 = rnd_g2 ^ 10'd1;
      ep_at = -1;
      for (int k = 0; k < 2046; k++) begin
         if (k % 2 == 0) rec2[k/2] = code_chip;
         if (epoch && ep_at < 0) ep_at = k;
         if (k == 600) begin
            addr = 3'd3;
            data = 32'(rnd_g2);
         end else begin
            addr = 3'd0;
         end
         run(1);
      end
      addr = 3'd0;
      chk("epoch2_cycle", 32'(ep_at), 32'd2045);
      mism = 0;
      for (int i = 0; i < 1023; i++)
         if (rec1[i] != rec2[i]) mism++;
      chk("period_repeat", 32'(mism), 32'd0);
      for (int i = 0; i < 10; i++) begin
         v3[9-i] = code_chip;
         m3[9-i] = m_code[i];
         run(2);
      end
      chk("g2_new_code", 32'(v3), 32'(m3));
      chk("g2_changed", 32'(v3 != prn1_exp), 32'd1);

      // Carrier NCO quarter-turn steps
      en = 0; rst = 1; run(1); rst = 0;
      wr(3'd1, 32'h40000000);
      wr(3'd2, 32'h0);
      en = 1;
      for (int i = 0; i < 8; i++) begin
         run(1);
         chk("car_phase", 32'(phase_upper), 32'(((i + 1) * 4) % 16));
         chk("car_sample", 32'(sample_out), ((i % 4) >= 2) ? 32'd0 : 32'd1);
      end

      // Nav handshake, bypass at boundary, underrun
      en = 0; rst = 1; run(1); rst = 0;
      wr(3'd2, 32'hFFFFFFFF);
      wr(3'd1, $urandom);
      en = 1; nbit = 1; nv = 1;
      run(1);
      nv = 0;
      chk("nav_ready_drop", 32'(nav_ready), 32'd0);
      wait_bit_edge(n);
      chk("bit_edge_cycle", 32'(n), 32'd20459);
      run(1);
      chk("nav_ready_rise", 32'(nav_ready), 32'd1);
      chk("nav1_no_underrun", 32'(underrun), 32'd0);
      p31 = phase_upper[3]; pc = code_chip;
      run(1);
      chk("nav1_sample_inv", 32'(sample_out), 32'(p31 ^ pc ^ 1'b1));
      wait_bit_edge(n);
      rb = 1'($urandom_range(0, 1));
      nbit = rb; nv = 1;
      run(1);
      nv = 0;
      chk("simul_no_underrun", 32'(underrun), 32'd0);
      chk("simul_ready", 32'(nav_ready), 32'd1);
      p31 = phase_upper[3]; pc = code_chip;
      run(1);
      chk("simul_sample", 32'(sample_out), 32'(p31 ^ pc ^ rb));
      wait_bit_edge(n);
      run(1);
      chk("underrun_set", 32'(underrun), 32'd1);
      p31 = phase_upper[3]; pc = code_chip;
      run(1);
      chk("underrun_zero_bit", 32'(sample_out), 32'(p31 ^ pc));
      wr(3'd6, 32'h0);
      chk("underrun_clear", 32'(underrun), 32'd0);

      // Reset mid-operation with a pending nav bit
      nbit = 1; nv = 1; run(1); nv = 0;
      run(37);
      rst = 1; run(1);
      chk("mid_rst_ready", 32'(nav_ready), 32'd1);
      chk("mid_rst_sample", 32'(sample_out), 32'd0);
      chk("mid_rst_chip", 32'(code_chip), 32'd1);
      chk("mid_rst_phase", 32'(phase_upper), 32'd0);
      chk("mid_rst_underrun", 32'(underrun), 32'd0);
      chk("mid_rst_epoch", 32'(epoch), 32'd0);
      chk("mid_rst_bit_edge", 32'(bit_edge), 32'd0);
      rst = 0;

      // Enable low freezes the NCOs and code
      wr(3'd1, $urandom | 32'h1);
      wr(3'd2, 32'hFFFFFFFF);
      run(50);
      en = 0;
      cap_phase = phase_upper; cap_chip = code_chip;
      chg = 0; eps = 0;
      repeat (100) begin
         run(1);
         if (epoch) eps++;
         if (phase_upper != cap_phase || code_chip != cap_chip) chg++;
      end
      chk("frozen", 32'(chg), 32'd0);
      chk("frozen_no_epoch", 32'(eps), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 3) != 0);
         n = $urandom_range(0, 15);
         addr = (n < 8) ? 3'd0 : 3'(n - 8);
         data = $urandom;
         nv = 1'($urandom_range(0, 1));
         nbit = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 499) == 0);
         run(1);
      end
      rst = 0; addr = 0; nv = 0; en = 0;
      run(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gps_signal_gen.md
Name: gps_signal_gen

Overview:
- Baseband GPS L1 C/A transmitter: synthesises a 1-bit IF sample stream = carrier sign XOR C/A chip XOR nav data bit.
- Serves as the on-chip stimulus source feeding the tracking channels' `sample` input for loopback bringup and self-test.
- Contains:
  - carrier NCO
  - code NCO
  - G1/G2 PRN generator
  - chip/epoch/bit counters
  - one-deep nav-bit buffer with valid/ready handshake

Parameters:
- CHIPS_PER_EPOCH, 1023, chips per C/A code period.
- EPOCHS_PER_BIT, 20, code epochs per nav data bit.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  advance NCOs/counters when high; all state holds when low
- address  in  3  register select; 0 = no-op
- data_value  in  32  register write data, written every cycle address != 0
- nav_bit  in  1  next nav data bit
- nav_valid  in  1  nav_bit valid
- nav_ready  out  1  nav buffer empty; transfer when nav_valid & nav_ready
- sample_out  out  1  registered IF sample
- code_chip  out  1  current C/A chip
- carrier_phase_upper  out  4  carrier accumulator [31:28]
- epoch  out  1  one-cycle pulse at code period wrap
- bit_edge  out  1  one-cycle pulse at nav bit boundary
- underrun  out  1  sticky: bit boundary reached with no nav bit available

Behaviour:
- Registers, effective next cycle:
  - 1 carrier_step, reset 32'h01FF0000
  - 2 code_step, reset 32'h0FFF0000
  - 3 g2_init[9:0], reset 10'b0011011111 (PRN1)
  - 4 carrier phase load: accumulator <= data_value, overrides that cycle's add
  - 5 code phase load: same, on the code accumulator
  - 6 clear underrun
  - 7 reserved, ignored
- NCOs: 32-bit accumulators, modulo 2^32. When enabled, acc <= acc + step each cycle.
- chip_tick = carry-out of the code add (enabled cycles only). A code phase load cycle produces no tick.
- PRN generator:
  - G1 = 1+x^3+x^10, G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10, shifting toward stage 10.
  - chip = G1[10]^G2[10]. Shift on chip_tick.
- Chip counter 0..1022:
  - On a tick at count 1022: counter <= 0, G1 <= all ones, G2 <= g2_init, epoch pulses that cycle.
  - New g2_init takes effect only at the next epoch or at reset.
- Epoch counter 0..19: increments on epoch. At 19 it wraps to 0 and bit_edge pulses in the same cycle as epoch.
- Nav path:
  - buffer (1 bit + full flag); nav_ready = ~full.
  - On bit_edge: current_bit <= buffer and full cleared. If the buffer is empty, current_bit <= 0 and underrun set.
  - Simultaneous bit_edge and transfer into an empty buffer: incoming bit goes straight to current_bit, no underrun, buffer stays empty.
  - Transfer while full is impossible, since ready is low.
- sample_out <= carrier_acc[31] ^ chip ^ current_bit, registered. One cycle latency from the accumulator/LFSR state to the output.
- Reset values:
  - all outputs 0 except nav_ready=1 and code_chip = G1[10]^g2_init[9]
  - accumulators 0, counters 0, G1 all ones, G2 = g2_init reset value, current_bit 0
- Reset mid-operation: returns to the above next cycle; a pending nav bit is discarded.
- enable low: accumulators, counters and LFSRs frozen; register writes still accepted; nav handshake still accepted; no epoch/bit_edge pulses.

Decomposition:
- Package gps_pkg:
  - CHIPS_PER_EPOCH, EPOCHS_PER_BIT
  - register address constants
  - G1/G2 feedback tap masks
  - PRN1 g2_init constant
- Sub-module gps_prn_lfsr: G1/G2 registers with shift, reload, g2_init input and chip output. Reusable by future receiver channels.

Test Plan:
- PRN1 code: reset, code_step=32'h80000000, carrier_step=0, enable -> chip tick every 2 cycles; code_chip first 10 chips 1,1,0,0,1,0,0,0,0,0 (octal 1440).
- Period: same setup -> epoch pulses after exactly 2046 enabled cycles; chip sequence repeats bit-exact; g2_init written mid-epoch changes code only after the next epoch.
- Carrier: carrier_step=32'h40000000, code_step=0, nav idle -> sample_out repeats 0,0,1,1 pattern with one-cycle latency; carrier_phase_upper steps 4,8,C,0.
- Nav handshake: nav_bit=1 offered early -> nav_ready drops after transfer; at first bit_edge (20 epochs) sample_out inverts versus the nav=0 reference and nav_ready rises. Transfer in the same cycle as bit_edge with an empty buffer -> no underrun.
- Underrun: no nav bit offered -> at bit_edge, underrun=1 and current_bit=0; address 6 write clears underrun.
- Reset mid-operation and enable low: assert reset mid-epoch -> all outputs at reset values next cycle; enable low for 100 cycles -> carrier_phase_upper and code_chip frozen, no epoch pulses.
